fixed_point_div_seq: RTL and testbench

Parametrised sequential unsigned fixed-point divider and the successor to the fixed 10-bit divider datapath. It computes q = floor(A·2^FRAC / B) for A, B and q all in the same unsigned Q(WIDTH−FRAC).FRAC format, using restoring division at one quotient bit per clock. Compared with the previous divider it adds:

- a start/busy/done handshake;
- divide-by-zero detection;
- optional saturation on overflow.

It sits behind the operand-load registers in the arithmetic unit and is driven by the controller FSM.

---
 rtl/fixed_point_div_seq.sv | 136 +++++++++++++
 tb/tb_fixed_point_div_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fixed_point_div_seq.sv
// rtl/fixed_point_div_seq.sv - sequential restoring unsigned fixed-point divider
module fixed_point_div_seq #(
  parameter int WIDTH    = 10,
  parameter int FRAC     = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             ov,
  output logic             dz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [N-1:0]     d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [N-1:0]     qs_reg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [N-1:0]     qs_next;
  logic             ov_next;

  assign accept    = start && (state != RUN);
  assign b_zero    = (b_reg == '0);
  assign last_iter = (cnt == CW'(N - 1));

  // One restoring step: bring down the next dividend bit and try to subtract.
  // The partial remainder is always below b_reg, so WIDTH bits hold it; only
  // the trial value needs the extra bit.
  always_comb begin
    trial    = {r_reg, d_reg[N-1]};
    trial_ge = (trial >= {1'b0, b_reg});
    qs_next  = N'({qs_reg, trial_ge});
    ov_next  = |(qs_next >> WIDTH);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode; a start in DONE chains straight into a new division.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = b_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = b_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers, iteration datapath and result registers. Results are
  // only written on the edge that enters DONE so they stay stable during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      qs_reg <= '0;
      cnt    <= '0;
      q      <= '0;
      ov     <= 1'b0;
      dz     <= 1'b0;
    end else begin
      if (state != RUN) begin
        if (ld_a) a_reg <= A;
        if (ld_b) b_reg <= B;
      end

      if (accept) begin
        if (b_zero) begin
          q  <= '1;
          ov <= 1'b1;
          dz <= 1'b1;
        end else begin
          d_reg  <= N'(a_reg) << FRAC;
          r_reg  <= '0;
          qs_reg <= '0;
          cnt    <= '0;
        end
      end else if (state == RUN) begin
        d_reg  <= d_reg << 1;
        r_reg  <= WIDTH'(trial_ge ? (trial - {1'b0, b_reg}) : trial);
        qs_reg <= qs_next;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          ov <= ov_next;
          dz <= 1'b0;
          q  <= (SATURATE && ov_next) ? '1 : qs_next[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_div_seq.sv
// tb/tb_fixed_point_div_seq.sv - directed self-checking bench for fixed_point_div_seq
module tb_fixed_point_div_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_a = 1'b0;
  logic       ld_b = 1'b0;
  logic       start = 1'b0;
  logic [9:0] A = '0;
  logic [9:0] B = '0;

  logic       busy, done, ov, dz;
  logic [9:0] q;
  logic       busy0, done0, ov0, dz0;
  logic [9:0] q0;

  int checks = 0;
  int failures = 0;
  logic [9:0] prev_q = '0;

  fixed_point_div_seq #(.WIDTH(10), .FRAC(4), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .A(A), .B(B),
    .start(start), .busy(busy), .done(done), .q(q), .ov(ov), .dz(dz)
  );

  fixed_point_div_seq #(.WIDTH(10), .FRAC(4), .SATURATE(1'b0)) dut_nosat (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .A(A), .B(B),
    .start(start), .busy(busy0), .done(done0), .q(q0), .ov(ov0), .dz(dz0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Optionally loads operands, pulses start and measures edges-to-done and busy cycles.
  // With poke set, start and ld_a(A=5) are pulsed in the middle of RUN.
  task automatic do_div(input string tag, input bit load, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] eq, input logic [9:0] eq0, input bit eov, input bit edz,
                        input int elat, input bit poke);
    int edges;
    int bc;
    bit seen;
    if (load) begin
      @(negedge clk);
      A = a; B = b; ld_a = 1'b1; ld_b = 1'b1;
    end
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b1;
    edges = 0; bc = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0; ld_a = 1'b0;
      if (busy) bc++;
      if (poke && busy && bc == 5) begin
        check({tag, "_q_stable_run"}, q, prev_q);
        start = 1'b1; ld_a = 1'b1; A = 10'd5;
      end
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, edges - 1, elat);
    check({tag, "_busy_cycles"}, bc, elat);
    check({tag, "_q"}, q, eq);
    check({tag, "_q_nosat"}, q0, eq0);
    check({tag, "_ov"}, ov, eov);
    check({tag, "_ov_nosat"}, ov0, eov);
    check({tag, "_dz"}, dz, edz);
    prev_q = eq;
    @(negedge clk);
    check({tag, "_done_pulse_width"}, done, 0);
  endtask

  initial begin
    bit ok;
    int dcount;

    repeat (2) @(negedge clk);
    check("rst_q", q, 0);
    check("rst_ov", ov, 0);
    check("rst_dz", dz, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 3.0 / 1.5 = 2.0
    do_div("basic", 1'b1, 10'd48, 10'd24, 10'd32, 10'd32, 1'b0, 1'b0, 14, 1'b0);
    // 1.0 / 3.0 = 0.3125 after truncation
    do_div("trunc", 1'b1, 10'd16, 10'd48, 10'd5, 10'd5, 1'b0, 1'b0, 14, 1'b0);
    // 1023*16 = 16368 does not fit: saturate to 1023, wrap to 1008
    do_div("overflow", 1'b1, 10'd1023, 10'd1, 10'd1023, 10'd1008, 1'b1, 1'b0, 14, 1'b0);
    // divide by zero: immediate done, all-ones in both modes
    do_div("div0", 1'b1, 10'd100, 10'd0, 10'd1023, 10'd1023, 1'b1, 1'b1, 0, 1'b0);
    // start and ld_a during RUN are ignored
    do_div("poke", 1'b1, 10'd48, 10'd24, 10'd32, 10'd32, 1'b0, 1'b0, 14, 1'b1);
    // reuse registered operands: a_reg must still be 48
    do_div("a_reg_kept", 1'b0, 10'd0, 10'd0, 10'd32, 10'd32, 1'b0, 1'b0, 14, 1'b0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    A = 10'd16; B = 10'd48; ld_a = 1'b1; ld_b = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    check("b2b_first_done", ok, 1);
    check("b2b_first_q", q, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_gap", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(ok);
    check("b2b_second_done", ok, 1);
    check("b2b_second_q", q, 5);

    // reset in the middle of RUN
    @(negedge clk);
    A = 10'd48; B = 10'd24; ld_a = 1'b1; ld_b = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_q", q, 0);
    check("midrst_ov", ov, 0);
    check("midrst_dz", dz, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    // operand registers were cleared by reset, so this is a divide by zero
    do_div("post_rst_div0", 1'b0, 10'd0, 10'd0, 10'd1023, 10'd1023, 1'b1, 1'b1, 0, 1'b0);
    do_div("post_rst_fresh", 1'b1, 10'd16, 10'd48, 10'd5, 10'd5, 1'b0, 1'b0, 14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
